// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The optional checksum stage (LOADER_CHECKSUM_EN) adds the CHK state to the enum.
package loader_pkg;
   localparam int DEPTH_DEF      = 256;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      WRITE,
`ifdef LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and status lines of the loader.
interface prog_loader_if #(parameter int AW = 32);
   logic          start;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold;
   logic          busy;
   logic          done;
   logic          err;

   modport slave (
      input  start, rx_data, rx_valid,
      output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
   );

   modport master (
      output start, rx_data, rx_valid,
      input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
   );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Shifts accepted bytes into a little-endian word; word_ready_o pulses with the last byte.
// word_o is the complete word in that same cycle (current byte merged combinationally).
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_ready_o
);
   localparam int CW = $clog2(BYTES_PER_WORD);

   logic [CW-1:0] cnt_q;
   logic [31:0]   word_q;

   // Newest byte enters at the top, so the first byte ends up in bits 7:0.
   assign word_o       = {byte_i, word_q[31:8]};
   assign word_ready_o = byte_en_i && (cnt_q == CW'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else if (clear_i) begin
         cnt_q  <= '0;
      end else if (byte_en_i) begin
         cnt_q  <= cnt_q + 1'b1;
         word_q <= word_o;
      end
   end
endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module prog_loader
   import loader_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = 32
)(
   input  logic            clk,
   input  logic            rst,
   prog_loader_if.slave    bus
);
   localparam int IW = $clog2(DEPTH + 1);

   state_t         state_q, state_d;
   logic [15:0]    n_q, n_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           we_q;
   logic [AW-1:0]  addr_q;
   logic [31:0]    wdata_q;
   logic           restart, byte_en, word_ready, xfer, chk_ok;
   logic [31:0]    word_full;

   always_comb begin
      bus.rx_ready = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA);
`ifdef LOADER_CHECKSUM_EN
      if (state_q == CHK) bus.rx_ready = 1'b1;
`endif
   end

   assign xfer           = bus.rx_valid & bus.rx_ready;
   assign byte_en        = xfer && (state_q == DATA);
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.cpu_hold   = (state_q != DONE);
   assign bus.busy       = bus.rx_ready || (state_q == WRITE);
   assign bus.done       = (state_q == DONE);
   assign bus.err        = (state_q == ERR);

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] chk_q;
   assign chk_ok = (bus.rx_data == chk_q);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         chk_q <= '0;
      else if (restart) chk_q <= '0;
      else if (byte_en) chk_q <= chk_q ^ bus.rx_data;
   end
`else
   assign chk_ok = 1'b1;
`endif

   word_assembler u_asm (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (restart),
      .byte_en_i    (byte_en),
      .byte_i       (bus.rx_data),
      .word_o       (word_full),
      .word_ready_o (word_ready)
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      restart = 1'b0;
      case (state_q)
         IDLE, DONE, ERR: if (bus.start) begin
            state_d = LEN0;
            idx_d   = '0;
            restart = 1'b1;
         end
         LEN0: if (xfer) begin
            n_d[7:0] = bus.rx_data;
            state_d  = LEN1;
         end
         LEN1: if (xfer) begin
            n_d[15:8] = bus.rx_data;
            if (n_d == 16'd0)              state_d = DONE;
            else if (32'(n_d) > 32'(DEPTH)) state_d = ERR;
            else                           state_d = DATA;
         end
         DATA: if (word_ready) state_d = WRITE;
         WRITE: begin
            idx_d = idx_q + 1'b1;
            if (16'(idx_d) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = CHK;
`else
               state_d = DONE;
`endif
            end else begin
               state_d = DATA;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHK: if (xfer) state_d = chk_ok ? DONE : ERR;
`endif
         default: state_d = IDLE;
      endcase
   end

   // Write port registers load on the last byte so they are valid throughout WRITE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         we_q    <= word_ready;
         if (word_ready) begin
            addr_q  <= AW'({idx_q, 2'b00});
            wdata_q <= word_full;
         end
      end
   end

   logic unused_ok;
   assign unused_ok = chk_ok;
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: builds byte streams from word lists and
// compares observed memory writes and final status against the expected load outcome.
module tb_prog_loader;
   localparam int DEPTH = 256;
   localparam int AW    = 32;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   logic [31:0] exp_words[$];
   logic [31:0] preset_q[$];
   logic [7:0]  stream[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] mem_model [0:255];

   prog_loader_if #(.AW(AW)) bus ();

   prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory-side observer: records every write and checks no byte is accepted during it.
   always @(negedge clk) begin
      if (rst && bus.imem_we) begin
         wr_addr_q.push_back(bus.imem_addr);
         wr_data_q.push_back(bus.imem_wdata);
         mem_model[bus.imem_addr[9:2]] = bus.imem_wdata;
         check_eq("ready_in_write", 64'(bus.rx_ready), 64'd0);
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
      check_eq({tag, "_we"},       64'(bus.imem_we), 64'd0);
      check_eq({tag, "_addr"},     64'(bus.imem_addr), 64'd0);
      check_eq({tag, "_wdata"},    64'(bus.imem_wdata), 64'd0);
      check_eq({tag, "_cpu_hold"}, 64'(bus.cpu_hold), 64'd1);
      check_eq({tag, "_busy"},     64'(bus.busy), 64'd0);
      check_eq({tag, "_done"},     64'(bus.done), 64'd0);
      check_eq({tag, "_err"},      64'(bus.err), 64'd0);
   endtask

   // mode 0: rx_valid always high, 1: random gaps, 2: toggles every cycle.
   task automatic do_load(input string tag, input int n, input int mode,
                          input bit chk_good, input int abort_after);
      int   idx, cyc, exp_nw, nw;
      bit   v, exp_err;
      logic [7:0]  x, b;
      logic [31:0] w;
      exp_words.delete();
      stream.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      stream.push_back(8'(n));
      stream.push_back(8'(n >> 8));
      exp_err = (n > DEPTH);
      x = 8'h00;
      if (!exp_err) begin
         for (int i = 0; i < n; i++) begin
            w = (preset_q.size() > i) ? preset_q[i] : $urandom;
            exp_words.push_back(w);
            for (int k = 0; k < 4; k++) begin
               b = 8'((w >> (8 * k)) & 32'hFF);
               stream.push_back(b);
               x = x ^ b;
            end
         end
      end
`ifdef LOADER_CHECKSUM_EN
      if (n > 0 && !exp_err) begin
         stream.push_back(chk_good ? x : (x ^ 8'h13));
         if (!chk_good) exp_err = 1'b1;
      end
`endif
      exp_nw = (n <= DEPTH) ? n : 0;

      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < stream.size() && cyc < 20000) begin
         if (abort_after > 0 && wr_addr_q.size() >= abort_after) break;
         if (mode == 0)      v = 1'b1;
         else if (mode == 1) v = ($urandom_range(0, 3) != 0);
         else                v = (cyc % 2 == 0);
         bus.rx_valid = v;
         bus.rx_data  = v ? stream[idx] : 8'($urandom);
         if (v && bus.rx_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      bus.rx_valid = 1'b0;

      if (abort_after > 0) begin
         rst = 1'b0;
         #1;
         check_reset_outputs({tag, "_abort"});
         check_eq({tag, "_nwrites"}, 64'(wr_addr_q.size()), 64'(abort_after));
         for (int i = 0; i < abort_after; i++)
            check_eq({tag, "_kept"}, 64'(mem_model[i]), 64'(exp_words[i]));
         @(negedge clk);
         check_reset_outputs({tag, "_held"});
         rst = 1'b1;
         @(negedge clk);
         $display("load %s n=%0d aborted after %0d writes", tag, n, abort_after);
         return;
      end

      while (!(bus.done || bus.err) && cyc < 25000) begin
         @(negedge clk);
         cyc++;
      end
      check_eq({tag, "_finished"}, 64'(bus.done || bus.err), 64'd1);
      check_eq({tag, "_done"},     64'(bus.done), 64'(!exp_err));
      check_eq({tag, "_err"},      64'(bus.err), 64'(exp_err));
      check_eq({tag, "_cpu_hold"}, 64'(bus.cpu_hold), 64'(exp_err));
      check_eq({tag, "_busy"},     64'(bus.busy), 64'd0);
      nw = wr_addr_q.size();
      check_eq({tag, "_nwrites"},  64'(nw), 64'(exp_nw));
      for (int i = 0; i < nw && i < exp_nw; i++) begin
         check_eq({tag, "_addr"}, 64'(wr_addr_q[i]), 64'(4 * i));
         check_eq({tag, "_data"}, 64'(wr_data_q[i]), 64'(exp_words[i]));
      end
      if (mode == 0 && n == 0)
         check_eq({tag, "_len0_latency"}, 64'(cyc), 64'd2);
      if (mode == 0 && n > 0 && n <= DEPTH)
         check_eq({tag, "_throughput"}, 64'(cyc <= 5 * n + 5), 64'd1);
      $display("load %s n=%0d mode=%0d writes=%0d cycles=%0d done=%0b err=%0b",
               tag, n, mode, nw, cyc, bus.done, bus.err);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b0;
      bus.start    = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      bus.rx_valid = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_ignores_valid_busy",  64'(bus.busy), 64'd0);
      check_eq("idle_ignores_valid_ready", 64'(bus.rx_ready), 64'd0);
      bus.rx_valid = 1'b0;

      preset_q = '{32'h0000_0013, 32'h0010_0093};
      do_load("basic", 2, 0, 1'b1, 0);
      preset_q.delete();

      do_load("len_zero", 0, 0, 1'b1, 0);
      do_load("too_long", 257, 0, 1'b1, 0);
      do_load("after_err", 1, 0, 1'b1, 0);
      do_load("toggle", 3, 2, 1'b1, 0);
      do_load("abort", 3, 0, 1'b1, 2);
      do_load("after_abort", 2, 1, 1'b1, 0);

      for (int t = 0; t < 6; t++)
         do_load("rand", int'($urandom_range(1, 8)), 1, 1'b1, 0);
      do_load("rand_too_long", int'($urandom_range(258, 65535)), 1, 1'b1, 0);

      do_load("max", DEPTH, 0, 1'b1, 0);
      check_eq("max_last_addr", 64'(wr_addr_q[wr_addr_q.size() - 1]), 64'((DEPTH - 1) * 4));

`ifdef LOADER_CHECKSUM_EN
      preset_q = '{32'h0000_0013};
      do_load("chk_good", 1, 0, 1'b1, 0);
      do_load("chk_bad", 1, 0, 1'b0, 0);
      preset_q.delete();
      do_load("chk_rand_bad", int'($urandom_range(1, 5)), 1, 1'b0, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: DEPTH, 256, instruction-memory capacity in 32-bit words.
REQ-002 Parameter: AW, 32, width of imem_addr (byte address).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 rx_data  input  8  incoming byte stream (e.g. from UART receiver).
REQ-007 rx_valid  input  1  rx_data holds a valid byte.
REQ-008 rx_ready  output  1  loader accepts byte this cycle; transfer = rx_valid & rx_ready.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  AW  byte address of word written, always multiple of 4.
REQ-011 imem_wdata  output  32  word written.
REQ-012 cpu_hold  output  1  high keeps the CPU core in reset.
REQ-013 busy / done / err  output  1 each  load in progress / load completed / load aborted.

Function
REQ-014 States SHALL be IDLE, LEN0, LEN1, DATA, WRITE, (CHK), DONE, ERR.
REQ-015 IDLE: start -> LEN0; other inputs ignored.
REQ-016 rx_ready SHALL be 1 only in LEN0, LEN1, DATA, CHK; 0 elsewhere (no byte accepted in WRITE).
REQ-017 LEN0 captures count N[7:0], LEN1 captures N[15:8] (little-endian word count).
REQ-018 After LEN1: N==0 -> DONE; N>DEPTH -> ERR; else DATA.
REQ-019 DATA collects 4 bytes little-endian (first byte -> bits 7:0); 4th accepted byte -> WRITE next cycle.
REQ-020 WRITE lasts exactly one cycle: imem_we=1, imem_addr=word_idx*4, imem_wdata=assembled word; word_idx increments.
REQ-021 After WRITE: word_idx==N -> CHK if enabled else DONE; otherwise DATA.
REQ-022 Throughput: one word per 5 cycles minimum when rx_valid held high.
REQ-023 rx_valid gaps of any length SHALL stall without data loss or timeout.
REQ-024 imem_we SHALL be 0 and imem_addr/imem_wdata hold last values outside WRITE.
REQ-025 cpu_hold SHALL be 1 in every state except DONE; 0 in DONE.
REQ-026 busy=1 in LEN0..CHK; done=1 only in DONE; err=1 only in ERR.
REQ-027 start in DONE or ERR SHALL restart at LEN0 (cpu_hold re-asserted next cycle, word_idx cleared); start in LEN0..CHK ignored.
REQ-028 Last word of max load (N=DEPTH) writes address (DEPTH-1)*4; word_idx never wraps.

Reset
REQ-029 On rst low: state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0, word_idx=0, N=0.
REQ-030 Reset mid-load SHALL abort immediately; already written memory words are not cleared.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN defined: after last WRITE, CHK accepts one byte; equal to XOR of all data bytes -> DONE, else ERR.
REQ-032 Macro undefined: CHK state and checksum register absent; last WRITE -> DONE directly.

Structure
REQ-033 Package loader_pkg SHALL hold the state enum type, DEPTH default, byte-per-word constant (4).
REQ-034 One sub-module word_assembler (byte shift-in, byte counter, word_ready pulse) is natural; FSM stays in prog_loader.

Verification
REQ-035 Start, bytes 02 00 | 13 00 00 00 | 93 00 10 00 -> writes 0x00000013 @0, 0x00100093 @4, then done=1, cpu_hold=0.
REQ-036 Start, length 00 00 -> DONE two accepted bytes later, imem_we never asserted.
REQ-037 DEPTH=256, length 01 01 (257) -> ERR, err=1, cpu_hold=1, no writes; then start + valid 1-word load -> DONE.
REQ-038 rx_valid toggling 1/0 every cycle during a 3-word load -> same three writes, addresses 0,4,8, rx_ready=0 in WRITE cycles.
REQ-039 rst low after 2nd of 3 words -> all outputs at reset values next edge; words 0 and 1 retained in memory model.
REQ-040 With LOADER_CHECKSUM_EN, 1 word 13 00 00 00, checksum 13 -> DONE; checksum 00 -> ERR after write at address 0.
